// File: rtl/imm_extend_pipe.sv
// LEGv8 immediate generator: classifies the instruction format and produces the
// sign/zero-extended immediate through a 1- or 2-stage valid/ready pipeline.
module imm_extend_pipe #(
   parameter int WORD      = 64,
   parameter int INSTR_LEN = 32,
   parameter int STAGES    = 2,
   parameter int BR_SHIFT  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_LEN-1:0] instr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD-1:0]      imm,
   output logic [2:0]           fmt
);

   localparam logic [2:0] F_R = 3'd0, F_D = 3'd1, F_I = 3'd2, F_CB = 3'd3,
                          F_B = 3'd4, F_IW = 3'd5, F_ILL = 3'd7;

   // Low 26 instruction bits hold every immediate field of every format.
   typedef struct packed {
      logic [2:0]  fmt;
      logic [25:0] raw;
   } s1_t;

   // Widest opcode match first; MOVZ with hw>=2 cannot be represented in 32 bits.
   function automatic logic [2:0] decode(input logic [31:0] i);
      logic [2:0] f;
      f = F_ILL;
      if (i[31:21] == 11'b10001011000 || i[31:21] == 11'b11001011000 ||
          i[31:21] == 11'b10001010000 || i[31:21] == 11'b10101010000)
         f = F_R;
      else if (i[31:21] == 11'b11111000010 || i[31:21] == 11'b11111000000)
         f = F_D;
      else if (i[31:22] == 10'b1001000100 || i[31:22] == 10'b1101000100)
         f = F_I;
      else if (i[31:23] == 9'b110100101)
         f = (WORD == 32 && i[22]) ? F_ILL : F_IW;
      else if (i[31:25] == 7'b1011010)
         f = F_CB;
      else if (i[31:26] == 6'b000101)
         f = F_B;
      return f;
   endfunction

   function automatic logic [WORD-1:0] extend(input logic [2:0] f, input logic [25:0] r);
      logic [63:0] t;
      t = '0;
      case (f)
         F_D:  t = {{55{r[20]}}, r[20:12]};
         F_I:  t = {52'd0, r[21:10]};
         F_CB: t = {{45{r[23]}}, r[23:5]};
         F_B:  t = {{38{r[25]}}, r[25:0]};
         F_IW: t = {48'd0, r[20:5]} << {r[22:21], 4'b0000};
         default: t = '0;
      endcase
      if (BR_SHIFT != 0 && (f == F_CB || f == F_B))
         t = t << 2;
      return t[WORD-1:0];
   endfunction

   logic adv_out;
   assign adv_out = out_ready || !out_valid;

   generate
      if (STAGES == 2) begin : g_two
         s1_t  s1;
         logic v1;

         assign in_ready = !v1 || adv_out;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v1        <= 1'b0;
               s1        <= '0;
               out_valid <= 1'b0;
               imm       <= '0;
               fmt       <= '0;
            end else begin
               if (flush) begin
                  v1        <= 1'b0;
                  out_valid <= 1'b0;
               end else begin
                  if (in_ready) v1 <= in_valid;
                  if (adv_out)  out_valid <= v1;
               end
               // Data registers may load during flush; their valid bits are cleared.
               if (in_valid && in_ready)
                  s1 <= '{fmt: decode(instr), raw: instr[25:0]};
               if (adv_out && v1) begin
                  imm <= extend(s1.fmt, s1.raw);
                  fmt <= s1.fmt;
               end
            end
         end
      end else begin : g_one
         logic [2:0] dec;
         assign dec      = decode(instr);
         assign in_ready = adv_out;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_valid <= 1'b0;
               imm       <= '0;
               fmt       <= '0;
            end else begin
               if (flush)        out_valid <= 1'b0;
               else if (adv_out) out_valid <= in_valid;
               if (in_valid && adv_out) begin
                  imm <= extend(dec, instr[25:0]);
                  fmt <= dec;
               end
            end
         end
      end
   endgenerate

endmodule
